// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: segment patterns,
// segment indices and the scan-reader FSM state type.
package seg7_pkg;

  // Segment bit positions inside a pattern (active-low, 0 = lit).
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Patterns written MSB-first, so bit 6 (g) is the leftmost digit.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0011000;

  localparam logic [3:0] SEG_ERR_CODE = 4'hF;

  typedef enum logic {
    COLETA,
    OFERTA
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low segment pattern back to its BCD
// value; unknown patterns decode to SEG_ERR_CODE with err set.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       err
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    value = SEG_ERR_CODE;
    err   = 1'b1;
    case (pattern)
      SEG_0: begin value = 4'd0; err = 1'b0; end
      SEG_1: begin value = 4'd1; err = 1'b0; end
      SEG_2: begin value = 4'd2; err = 1'b0; end
      SEG_3: begin value = 4'd3; err = 1'b0; end
      SEG_4: begin value = 4'd4; err = 1'b0; end
      SEG_5: begin value = 4'd5; err = 1'b0; end
      SEG_6: begin value = 4'd6; err = 1'b0; end
      SEG_7: begin value = 4'd7; err = 1'b0; end
      SEG_8: begin value = 4'd8; err = 1'b0; end
      SEG_9: begin value = 4'd9; err = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Watches the multiplexed 7-segment pins, captures each digit once its
// pattern is stable, and offers completed frames on a valid/ready port.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    overrun
);

  localparam int SW = NUM_DIGITS + 7;
  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

  logic [SW-1:0]           s_q;
  logic [SW-1:0]           s_prev;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;
  logic [NUM_DIGITS-1:0]   mask;
  logic [NUM_DIGITS-1:0]   mask_hit;
  logic [4*NUM_DIGITS-1:0] wk_val;
  logic [4*NUM_DIGITS-1:0] wk_val_next;
  logic [NUM_DIGITS-1:0]   wk_err;
  logic [NUM_DIGITS-1:0]   wk_err_next;
  logic [NUM_DIGITS-1:0]   an_low;
  logic [3:0]              dec_val;
  logic                    dec_err;
  logic                    same;
  logic                    one_hot;
  logic                    capture;
  logic                    frame_done;
  state_t                  state;

  seg7_pattern_decode u_decode (
    .pattern (s_q[6:0]),
    .value   (dec_val),
    .err     (dec_err)
  );

  assign same     = (s_q == s_prev);
  assign cnt_next = !same ? CNT_W'(1) : ((cnt == STABLE) ? cnt : cnt + CNT_W'(1));
  assign an_low   = ~s_q[SW-1:7];
  assign one_hot  = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);

  // A capture fires only on the cycle the count reaches STABLE; a changed
  // sample that reloads 1 also counts when STABLE_CYCLES is 1.
  assign capture = one_hot && (cnt_next == STABLE) && ((cnt != STABLE) || !same);

  always_comb begin
    wk_val_next = wk_val;
    wk_err_next = wk_err;
    mask_hit    = mask;
    if (capture) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (an_low[k]) begin
          wk_val_next[4*k +: 4] = dec_val;
          wk_err_next[k]        = dec_err;
          mask_hit[k]           = 1'b1;
        end
      end
    end
  end

  assign frame_done = capture && (&mask_hit);

  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous and clears the working slots too, so a frame
    // interrupted by reset can never leak stale digits into the next one.
    if (reset) begin
      s_q         <= '0;
      s_prev      <= '0;
      cnt         <= '0;
      mask        <= '0;
      wk_val      <= '0;
      wk_err      <= '0;
      state       <= COLETA;
      frame_valid <= 1'b0;
      digits      <= '0;
      digit_err   <= '0;
      overrun     <= 1'b0;
    end else begin
      // NOTE: all state updates use non-blocking assignments so every register
      // sees the pre-edge values of the others, independent of statement order.
      s_q     <= {an_in, seg_in};
      s_prev  <= s_q;
      cnt     <= cnt_next;
      wk_val  <= wk_val_next;
      wk_err  <= wk_err_next;
      mask    <= frame_done ? '0 : mask_hit;
      overrun <= 1'b0;
      case (state)
        COLETA: begin
          if (frame_done) begin
            digits      <= wk_val_next;
            digit_err   <= wk_err_next;
            frame_valid <= 1'b1;
            state       <= OFERTA;
          end
        end
        OFERTA: begin
          if (frame_done && frame_ready) begin
            digits    <= wk_val_next;
            digit_err <= wk_err_next;
          end else if (frame_done) begin
            overrun <= 1'b1;
          end else if (frame_ready) begin
            frame_valid <= 1'b0;
            state       <= COLETA;
          end
        end
        default: state <= COLETA;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: expected frames are queued as
// digits are scanned and compared whenever the DUT hands a frame over.
module tb_seg7_scan_reader;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  e;
  } frame_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic        frame_ready;
  logic        frame_valid;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        overrun;

  frame_t exp_q[$];
  int     compared   = 0;
  int     mismatched = 0;
  int     ovr_count  = 0;

  seg7_scan_reader #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (3),
    .CNT_W         (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .digits      (digits),
    .digit_err   (digit_err),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  // Patterns are written in a..g reading order and flipped into bit order.
  function automatic logic [6:0] rev7(input logic [6:0] s);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = s[6-i];
    return r;
  endfunction

  function automatic logic [6:0] pat(input int v);
    case (v)
      0: return rev7(7'b0000001);
      1: return rev7(7'b1001111);
      2: return rev7(7'b0010010);
      3: return rev7(7'b0000110);
      4: return rev7(7'b1001100);
      5: return rev7(7'b0100100);
      6: return rev7(7'b0100000);
      7: return rev7(7'b0001111);
      8: return rev7(7'b0000000);
      9: return rev7(7'b0001100);
      default: return 7'b1111111;
    endcase
  endfunction

  // Scoreboard: every accepted frame is matched against the queue head.
  always @(negedge clock) begin
    frame_t got_exp;
    if (overrun) ovr_count++;
    if (!reset && frame_valid && frame_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_frame: got digits=%h err=%b, required no frame", digits, digit_err);
      end else begin
        got_exp = exp_q.pop_front();
        if (digits !== got_exp.d || digit_err !== got_exp.e) begin
          mismatched++;
          $display("FAIL frame_data: got digits=%h err=%b, required digits=%h err=%b",
                   digits, digit_err, got_exp.d, got_exp.e);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic show_digit(input int k, input int v);
    drive(~(4'b0001 << k), pat(v), 5);
  endtask

  task automatic blank(input int n);
    drive(4'hF, 7'h7F, n);
  endtask

  task automatic scan(input int v0, input int v1, input int v2, input int v3);
    show_digit(0, v0);
    show_digit(1, v1);
    show_digit(2, v2);
    show_digit(3, v3);
    blank(3);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clock);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_timeout: got %0d frames pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_cleared(input string tag);
    compared += 4;
    if (frame_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_valid: got %b, required 0", tag, frame_valid);
    end
    if (digits !== 16'h0) begin
      mismatched++;
      $display("FAIL %s_digits: got %h, required 0000", tag, digits);
    end
    if (digit_err !== 4'h0) begin
      mismatched++;
      $display("FAIL %s_err: got %b, required 0000", tag, digit_err);
    end
    if (overrun !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_overrun: got %b, required 0", tag, overrun);
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    frame_ready = 1'b1;
    an_in       = 4'hF;
    seg_in      = 7'h7F;
    repeat (3) @(posedge clock);
    #1;
    check_cleared("reset");
    reset = 1'b0;
  endtask

  task automatic test_basic();
    frame_ready = 1'b1;
    exp_q.push_back('{d: 16'h7543, e: 4'b0000});
    scan(3, 4, 5, 7);
    wait_drain(20);
  endtask

  task automatic test_short_hold();
    frame_ready = 1'b1;
    drive(4'b1110, pat(8), 2);
    show_digit(1, 2);
    show_digit(2, 6);
    show_digit(3, 0);
    blank(5);
    compared++;
    if (frame_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL short_hold_valid: got %b, required 0", frame_valid);
    end
    exp_q.push_back('{d: 16'h0629, e: 4'b0000});
    show_digit(0, 9);
    blank(3);
    wait_drain(20);
  endtask

  task automatic test_bad_pattern();
    frame_ready = 1'b1;
    exp_q.push_back('{d: 16'h9F18, e: 4'b0100});
    show_digit(0, 8);
    show_digit(1, 1);
    drive(4'b1011, 7'b1111111, 5);
    show_digit(3, 9);
    blank(3);
    wait_drain(20);
  endtask

  task automatic test_no_enable();
    logic [3:0] bad_an [3];
    bit         saw;
    bad_an[0] = 4'b1111;
    bad_an[1] = 4'b1100;
    bad_an[2] = 4'b0011;
    frame_ready = 1'b1;
    show_digit(0, 1);
    show_digit(1, 2);
    show_digit(2, 3);
    saw = 1'b0;
    for (int j = 0; j < 3; j++) begin
      an_in  = bad_an[j];
      seg_in = pat(5);
      for (int c = 0; c < 10; c++) begin
        @(negedge clock);
        if (frame_valid) saw = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    compared++;
    if (saw) begin
      mismatched++;
      $display("FAIL no_enable_frame: got frame_valid=1, required 0");
    end
    exp_q.push_back('{d: 16'h4321, e: 4'b0000});
    show_digit(3, 4);
    blank(3);
    wait_drain(20);
  endtask

  task automatic test_overrun();
    int ovr0;
    frame_ready = 1'b0;
    exp_q.push_back('{d: 16'h4321, e: 4'b0000});
    scan(1, 2, 3, 4);
    compared += 2;
    if (frame_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL ovr_first_valid: got %b, required 1", frame_valid);
    end
    if (digits !== 16'h4321) begin
      mismatched++;
      $display("FAIL ovr_first_digits: got %h, required 4321", digits);
    end
    ovr0 = ovr_count;
    scan(5, 6, 7, 8);
    compared += 3;
    if (ovr_count !== ovr0 + 1) begin
      mismatched++;
      $display("FAIL ovr_pulses: got %0d, required %0d", ovr_count - ovr0, 1);
    end
    if (digits !== 16'h4321) begin
      mismatched++;
      $display("FAIL ovr_held_digits: got %h, required 4321", digits);
    end
    if (frame_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL ovr_held_valid: got %b, required 1", frame_valid);
    end
    frame_ready = 1'b1;
    wait_drain(20);
    @(posedge clock);
    #1;
    compared++;
    if (frame_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL ovr_release_valid: got %b, required 0", frame_valid);
    end
  endtask

  task automatic test_back_to_back();
    int ovr0;
    frame_ready = 1'b0;
    exp_q.push_back('{d: 16'h6789, e: 4'b0000});
    scan(9, 8, 7, 6);
    ovr0 = ovr_count;
    exp_q.push_back('{d: 16'h3210, e: 4'b0000});
    show_digit(0, 0);
    show_digit(1, 1);
    show_digit(2, 2);
    an_in  = 4'b0111;
    seg_in = pat(3);
    repeat (3) @(posedge clock);
    #1;
    frame_ready = 1'b1;
    @(posedge clock);
    #1;
    frame_ready = 1'b0;
    blank(3);
    compared += 3;
    if (frame_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_valid: got %b, required 1", frame_valid);
    end
    if (digits !== 16'h3210) begin
      mismatched++;
      $display("FAIL b2b_digits: got %h, required 3210", digits);
    end
    if (ovr_count !== ovr0) begin
      mismatched++;
      $display("FAIL b2b_overrun: got %0d pulses, required 0", ovr_count - ovr0);
    end
    frame_ready = 1'b1;
    wait_drain(20);
  endtask

  task automatic test_reset_mid();
    frame_ready = 1'b1;
    show_digit(0, 9);
    show_digit(1, 9);
    an_in  = 4'hF;
    reset  = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_cleared("mid_reset");
    reset = 1'b0;
    show_digit(2, 1);
    show_digit(3, 2);
    blank(5);
    compared++;
    if (frame_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset_stale: got frame_valid=%b, required 0", frame_valid);
    end
    exp_q.push_back('{d: 16'h2154, e: 4'b0000});
    show_digit(0, 4);
    show_digit(1, 5);
    blank(3);
    wait_drain(20);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_hold();
    test_bad_pattern();
    test_no_enable();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    blank(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
